// File: rtl/mii_frame_checker.sv
// mii_frame_checker
// Receive-side MII frame checker. Parses idle / preamble / SFD / payload / EOF
// on an 8-bit byte stream with a control flag. Payload is forwarded through a
// one-byte hold register, so the last byte can carry o_eof once EOF is seen.
// Every terminated or aborted frame produces a single status pulse. Good and
// error frames are counted separately.
module mii_frame_checker #(
    parameter int         PREAMBLE_CYCLES = 7,
    parameter int         MIN_DATA        = 46,
    parameter int         MAX_DATA        = 1500,
    parameter logic [7:0] IDLE_CODE       = 8'h07,
    parameter logic [7:0] PREAMBLE_CODE   = 8'h55,
    parameter logic [7:0] SFD_CODE        = 8'hD5,
    parameter logic [7:0] EOF_CODE        = 8'hFD
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_ctrl,
    input  logic        i_clear,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_status_valid,
    output logic        o_status_ok,
    output logic [2:0]  o_err_code,
    output logic [15:0] o_frame_len,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_err_cnt
);

    // The preamble counter saturates one above the required count, so any
    // over-long preamble is still distinguishable from the exact one.
    localparam int            PW       = $clog2(PREAMBLE_CYCLES + 2);
    localparam logic [PW-1:0] PRE_FULL = PW'(PREAMBLE_CYCLES);
    localparam logic [PW-1:0] PRE_SAT  = PW'(PREAMBLE_CYCLES + 1);
    localparam logic [15:0]   MIN_LEN  = 16'(MIN_DATA);
    localparam logic [15:0]   MAX_LEN  = 16'(MAX_DATA);

    localparam logic [2:0] E_NONE      = 3'd0;
    localparam logic [2:0] E_BAD_START = 3'd1;
    localparam logic [2:0] E_PRE_LEN   = 3'd2;
    localparam logic [2:0] E_BAD_SFD   = 3'd3;
    localparam logic [2:0] E_CTRL_DATA = 3'd4;
    localparam logic [2:0] E_LEN_SHORT = 3'd5;
    localparam logic [2:0] E_LEN_LONG  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    state_t        r_state;
    logic [PW-1:0] r_pre_cnt;
    logic [15:0]   r_len;
    logic          r_hold_full;
    logic          r_hold_first;
    logic [7:0]    r_hold_data;

    state_t        w_state_nxt;
    logic [PW-1:0] w_pre_nxt;
    logic [15:0]   w_len_nxt;
    logic [15:0]   w_len_inc;
    logic          w_idle_or_eof;
    logic          w_emit;
    logic          w_eof;
    logic          w_hold_load;
    logic          w_hold_clr;
    logic          w_stat;
    logic          w_stat_ok;
    logic [2:0]    w_stat_code;
    logic [15:0]   w_stat_len;

    assign w_len_inc     = r_len + 16'd1;
    assign w_idle_or_eof = i_rx_ctrl && (i_rx_data == IDLE_CODE || i_rx_data == EOF_CODE);

    // Next-state, hold-register control and status decode for the sampled byte
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre_cnt;
        w_len_nxt   = r_len;
        w_emit      = 1'b0;
        w_eof       = 1'b0;
        w_hold_load = 1'b0;
        w_hold_clr  = 1'b0;
        w_stat      = 1'b0;
        w_stat_ok   = 1'b0;
        w_stat_code = E_NONE;
        w_stat_len  = 16'd0;
        case (r_state)
            S_IDLE: begin
                if (!i_rx_ctrl) begin
                    if (i_rx_data == PREAMBLE_CODE) begin
                        w_state_nxt = S_PRE;
                        w_pre_nxt   = PW'(1);
                    end else begin
                        w_stat      = 1'b1;
                        w_stat_code = E_BAD_START;
                        w_state_nxt = S_DROP;
                    end
                end
            end
            S_PRE: begin
                if (i_rx_ctrl) begin
                    w_stat      = 1'b1;
                    w_stat_code = E_PRE_LEN;
                    w_state_nxt = w_idle_or_eof ? S_IDLE : S_DROP;
                end else if (i_rx_data == PREAMBLE_CODE) begin
                    if (r_pre_cnt != PRE_SAT)
                        w_pre_nxt = r_pre_cnt + PW'(1);
                end else if (i_rx_data == SFD_CODE) begin
                    if (r_pre_cnt == PRE_FULL) begin
                        w_state_nxt = S_DATA;
                        w_len_nxt   = 16'd0;
                    end else begin
                        w_stat      = 1'b1;
                        w_stat_code = E_PRE_LEN;
                        w_state_nxt = S_DROP;
                    end
                end else begin
                    w_stat      = 1'b1;
                    w_stat_code = E_BAD_SFD;
                    w_state_nxt = S_DROP;
                end
            end
            S_DATA: begin
                if (!i_rx_ctrl) begin
                    if (w_len_inc > MAX_LEN) begin
                        // Oversize: held byte is dropped, frame aborted.
                        w_stat      = 1'b1;
                        w_stat_code = E_LEN_LONG;
                        w_stat_len  = w_len_inc;
                        w_hold_clr  = 1'b1;
                        w_state_nxt = S_DROP;
                    end else begin
                        w_len_nxt   = w_len_inc;
                        w_emit      = r_hold_full;
                        w_hold_load = 1'b1;
                    end
                end else if (i_rx_data == EOF_CODE) begin
                    w_stat      = 1'b1;
                    w_stat_len  = r_len;
                    w_stat_ok   = (r_len != 16'd0) && (r_len >= MIN_LEN);
                    w_stat_code = w_stat_ok ? E_NONE : E_LEN_SHORT;
                    w_emit      = r_hold_full;
                    w_eof       = r_hold_full;
                    w_hold_clr  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stat      = 1'b1;
                    w_stat_code = E_CTRL_DATA;
                    w_stat_len  = r_len;
                    w_hold_clr  = 1'b1;
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (w_idle_or_eof)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state, preamble count and payload length registers
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_pre_cnt <= '0;
            r_len     <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre_cnt <= w_pre_nxt;
            r_len     <= w_len_nxt;
        end
    end

    // One-byte hold register that delays payload until its successor (or EOF) is known
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_full  <= 1'b0;
            r_hold_first <= 1'b0;
            r_hold_data  <= 8'd0;
        end else if (w_hold_clr) begin
            r_hold_full  <= 1'b0;
        end else if (w_hold_load) begin
            r_hold_full  <= 1'b1;
            r_hold_first <= (r_len == 16'd0);
            r_hold_data  <= i_rx_data;
        end
    end

    // Registered payload and status outputs; status fields hold between pulses
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_data         <= 8'd0;
            o_valid        <= 1'b0;
            o_sof          <= 1'b0;
            o_eof          <= 1'b0;
            o_status_valid <= 1'b0;
            o_status_ok    <= 1'b0;
            o_err_code     <= 3'd0;
            o_frame_len    <= 16'd0;
        end else begin
            o_valid        <= w_emit;
            o_sof          <= w_emit & r_hold_first;
            o_eof          <= w_eof;
            o_status_valid <= w_stat;
            if (w_emit)
                o_data <= r_hold_data;
            if (w_stat) begin
                o_status_ok <= w_stat_ok;
                o_err_code  <= w_stat_code;
                o_frame_len <= w_stat_len;
            end
        end
    end

    // Good / error frame counters; clear beats a same-cycle increment
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_cnt <= 16'd0;
            o_err_cnt   <= 16'd0;
        end else if (i_clear) begin
            o_frame_cnt <= 16'd0;
            o_err_cnt   <= 16'd0;
        end else if (w_stat) begin
            if (w_stat_ok)
                o_frame_cnt <= o_frame_cnt + 16'd1;
            else
                o_err_cnt   <= o_err_cnt + 16'd1;
        end
    end

endmodule
